// File: rtl/cfbm_pkg.sv
// Shared definitions for the conflict-free bank mapper: mode encodings and
// the row-width helper used by the top and the lane hash.
package cfbm_pkg;

  typedef enum logic {
    MODE_PARITY  = 1'b0,
    MODE_XORFOLD = 1'b1
  } mode_e;

  function automatic int unsigned row_w(input int unsigned addr_w, input int unsigned bank_w);
    return addr_w - bank_w;
  endfunction

endpackage

// File: rtl/bank_hash.sv
// Combinational single-lane mapper: logical address + mode -> {bank, row}.
module bank_hash
  import cfbm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BANK_W = 3
) (
  input  logic [ADDR_W-1:0]                 addr,
  input  mode_e                             mode,
  output logic [BANK_W-1:0]                 bank_c,
  output logic [row_w(ADDR_W, BANK_W)-1:0]  row_c
);

  localparam int unsigned N_CHUNK = (ADDR_W + BANK_W - 1) / BANK_W;
  localparam int unsigned PAD_W   = N_CHUNK * BANK_W;

  logic [PAD_W-1:0]  addr_pad;
  logic [BANK_W-1:0] fold_c;
  logic [BANK_W-1:0] parity_c;

  assign addr_pad = PAD_W'(addr);
  assign row_c    = addr[ADDR_W-1:BANK_W];

  // XOR of every BANK_W-bit chunk; the top partial chunk is zero-padded.
  always_comb begin
    fold_c = '0;
    for (int unsigned c = 0; c < N_CHUNK; c++) begin
      fold_c = fold_c ^ addr_pad[c*BANK_W +: BANK_W];
    end
  end

  // Parity-zone: low bits pass through, bank MSB is the parity of the upper zone.
  if (BANK_W > 1) begin : g_low
    assign parity_c[BANK_W-2:0] = addr[BANK_W-2:0];
  end
  assign parity_c[BANK_W-1] = ^addr[ADDR_W-1:BANK_W-1];

  assign bank_c = (mode == MODE_XORFOLD) ? fold_c : parity_c;

endmodule

// File: rtl/conflict_free_bank_mapper.sv
// Maps LANES logical addresses per beat to {bank, row} through a 2-stage
// valid/ready pipeline, flags lanes that share a bank and counts conflicting beats.
module conflict_free_bank_mapper
  import cfbm_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BANK_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_mode,
  input  logic [LANES*ADDR_W-1:0]                  in_addr,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LANES*row_w(ADDR_W, BANK_W)-1:0]   out_row,
  output logic [LANES*BANK_W-1:0]                  out_bank,
  output logic                                     out_cros,
  output logic                                     out_conflict,
  output logic [LANES-1:0]                         out_conflict_mask,
  output logic [CNT_W-1:0]                         conflict_cnt,
  input  logic                                     cnt_clear
);

  localparam int unsigned ROW_W = row_w(ADDR_W, BANK_W);

  logic [LANES*BANK_W-1:0] hash_bank_c;
  logic [LANES*ROW_W-1:0]  hash_row_c;
  logic                    s1_valid;
  logic [LANES*BANK_W-1:0] s1_bank;
  logic [LANES*ROW_W-1:0]  s1_row;
  logic                    s1_load_c;
  logic                    s2_load_c;
  logic [LANES-1:0]        mask_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bank_hash #(
      .ADDR_W (ADDR_W),
      .BANK_W (BANK_W)
    ) u_hash (
      .addr   (in_addr[i*ADDR_W +: ADDR_W]),
      .mode   (mode_e'(in_mode)),
      .bank_c (hash_bank_c[i*BANK_W +: BANK_W]),
      .row_c  (hash_row_c[i*ROW_W +: ROW_W])
    );
  end

  // Stage 2 is the output register, so out_valid doubles as its valid flag.
  assign s2_load_c = !out_valid || out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;
  assign in_ready  = s1_load_c;

  // Lane i conflicts when any other lane targets the same bank.
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (i != j && s1_bank[i*BANK_W +: BANK_W] == s1_bank[j*BANK_W +: BANK_W]) begin
          mask_c[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      s1_row   <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_bank <= hash_bank_c;
        s1_row  <= hash_row_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_bank          <= '0;
      out_row           <= '0;
      out_conflict_mask <= '0;
      out_conflict      <= 1'b0;
      out_cros          <= 1'b0;
    end else if (s2_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_bank          <= s1_bank;
        out_row           <= s1_row;
        out_conflict_mask <= mask_c;
        out_conflict      <= |mask_c;
        out_cros          <= s1_bank[BANK_W-1];
      end
    end
  end

  // Saturating count of delivered conflicting beats; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      conflict_cnt <= '0;
    end else if (out_valid && out_ready && out_conflict && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
